// File: rtl/record_controller_pkg.sv
// -----------------------------------------------------------------------------
// record_controller_pkg
// Shared song-format definitions used by both the recorder (record_controller)
// and the playback side (song_player):
//   - master_state mode encodings
//   - song-RAM geometry (RAM_DEPTH entries, ADDR_W address bits)
//   - 16-bit entry layout {rest[15], note[14:9], duration[8:3], meta[2:0]}
//   - MAX_DUR, the longest duration a single entry can carry
//   - recorder FSM state type
// -----------------------------------------------------------------------------
package record_controller_pkg;

    typedef enum logic [1:0] {
        MS_JAM_SESH    = 2'b00,
        MS_COMPOSER    = 2'b01,
        MS_SONG_PLAYER = 2'b10
    } master_state_e;

    localparam int unsigned NOTE_W    = 6;
    localparam int unsigned DUR_W     = 6;
    localparam int unsigned META_W    = 3;
    localparam int unsigned ADDR_W    = 7;
    localparam int unsigned PAYLOAD_W = 16;
    localparam int unsigned RAM_DEPTH = 128;

    // Entry field positions
    localparam int unsigned PAY_REST_BIT = 15;
    localparam int unsigned PAY_NOTE_LSB = 9;
    localparam int unsigned PAY_DUR_LSB  = 3;
    localparam int unsigned PAY_META_LSB = 0;

    localparam logic [DUR_W-1:0]  MAX_DUR   = 6'd63;
    localparam logic [ADDR_W-1:0] LAST_ADDR = 7'(RAM_DEPTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REC,
        ST_FLUSH,
        ST_DONE
    } rec_state_e;

    // Build one song-RAM entry; note 0 is a rest, meta is always zero.
    function automatic logic [PAYLOAD_W-1:0] pack_entry(
        input logic [NOTE_W-1:0] note,
        input logic [DUR_W-1:0]  dur
    );
        logic [PAYLOAD_W-1:0] p;
        p = '0;
        p[PAY_REST_BIT]                        = (note == '0);
        p[PAY_NOTE_LSB +: NOTE_W]              = note;
        p[PAY_DUR_LSB  +: DUR_W]               = dur;
        p[PAY_META_LSB +: META_W]              = '0;
        return p;
    endfunction

endpackage

// File: rtl/record_controller.sv
// -----------------------------------------------------------------------------
// record_controller
// Records live key events into song RAM while in COMPOSER mode. Each entry is
// a note (or rest) plus how many beats it was held. Notes held for MAX_DUR
// beats are split into several entries. Recording stops on record_button,
// on leaving COMPOSER mode, or when the last RAM slot is written.
//
// Ports
//   clk            in   system clock, rising edge
//   reset          in   asynchronous active-low reset
//   beat           in   one-cycle tempo pulse
//   master_state   in   [1:0] mode (JAM_SESH / COMPOSER / SONG_PLAYER)
//   record_button  in   one-cycle start/stop pulse
//   note_valid     in   one-cycle pulse qualifying note_in
//   note_in        in   [5:0] note index, 0 = rest
//   write_enable   out  song-RAM write strobe, one cycle per entry
//   write_address  out  [6:0] entry index
//   write_payload  out  [15:0] entry data
//   done_recording out  one-cycle pulse; write_address = last written index
//   recording      out  high while recording or flushing
//   full           out  high from the write to the last slot until next start
// -----------------------------------------------------------------------------
module record_controller
    import record_controller_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 beat,
    input  logic [1:0]           master_state,
    input  logic                 record_button,
    input  logic                 note_valid,
    input  logic [NOTE_W-1:0]    note_in,
    output logic                 write_enable,
    output logic [ADDR_W-1:0]    write_address,
    output logic [PAYLOAD_W-1:0] write_payload,
    output logic                 done_recording,
    output logic                 recording,
    output logic                 full
);

    rec_state_e             state_q;
    logic [ADDR_W-1:0]      addr_q;
    logic [NOTE_W-1:0]      cur_note_q;
    logic [DUR_W-1:0]       dur_q;
    logic                   wrote_any_q;

    logic                   write_enable_q;
    logic [ADDR_W-1:0]      write_address_q;
    logic [PAYLOAD_W-1:0]   write_payload_q;
    logic                   done_recording_q;
    logic                   recording_q;
    logic                   full_q;

    logic                   is_composer;
    logic                   stop_req;
    logic [DUR_W-1:0]       dur_credit;
    logic                   note_change;
    logic                   split;
    logic                   do_write;
    logic                   last_slot;

    // The beat of this cycle is credited to the current note before any
    // entry is formed, so every decision below works on dur_credit.
    always_comb begin
        is_composer = (master_state == MS_COMPOSER);
        stop_req    = record_button || !is_composer;
        dur_credit  = dur_q + DUR_W'(beat);
        note_change = note_valid && (note_in != cur_note_q) && !stop_req;
        split       = beat && (dur_credit == MAX_DUR);
        do_write    = (note_change && (dur_credit != '0)) || split;
        last_slot   = (addr_q == LAST_ADDR);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= ST_IDLE;
            addr_q           <= '0;
            cur_note_q       <= '0;
            dur_q            <= '0;
            wrote_any_q      <= 1'b0;
            write_enable_q   <= 1'b0;
            write_address_q  <= '0;
            write_payload_q  <= '0;
            done_recording_q <= 1'b0;
            recording_q      <= 1'b0;
            full_q           <= 1'b0;
        end else begin
            write_enable_q   <= 1'b0;
            done_recording_q <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (record_button && is_composer) begin
                        state_q     <= ST_REC;
                        addr_q      <= '0;
                        cur_note_q  <= '0;
                        dur_q       <= '0;
                        wrote_any_q <= 1'b0;
                        full_q      <= 1'b0;
                        recording_q <= 1'b1;
                    end
                end

                ST_REC: begin
                    if (do_write) begin
                        write_enable_q  <= 1'b1;
                        write_address_q <= addr_q;
                        write_payload_q <= pack_entry(cur_note_q, dur_credit);
                        addr_q          <= addr_q + 1'b1;
                        wrote_any_q     <= 1'b1;
                        dur_q           <= '0;
                    end else begin
                        dur_q <= dur_credit;
                    end

                    // A zero-length note is simply replaced without a write.
                    if (note_change) begin
                        cur_note_q <= note_in;
                    end

                    // Filling the last slot ends the take immediately; any
                    // remaining duration is dropped rather than flushed.
                    if (do_write && last_slot) begin
                        full_q      <= 1'b1;
                        recording_q <= 1'b0;
                        state_q     <= ST_DONE;
                    end else if (stop_req) begin
                        state_q <= ST_FLUSH;
                    end
                end

                ST_FLUSH: begin
                    if (dur_q != '0) begin
                        write_enable_q  <= 1'b1;
                        write_address_q <= addr_q;
                        write_payload_q <= pack_entry(cur_note_q, dur_q);
                        addr_q          <= addr_q + 1'b1;
                        wrote_any_q     <= 1'b1;
                        dur_q           <= '0;
                        if (last_slot) begin
                            full_q <= 1'b1;
                        end
                    end
                    recording_q <= 1'b0;
                    state_q     <= ST_DONE;
                end

                ST_DONE: begin
                    // write_address_q still holds the last written index here.
                    done_recording_q <= wrote_any_q;
                    state_q          <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign write_enable   = write_enable_q;
    assign write_address  = write_address_q;
    assign write_payload  = write_payload_q;
    assign done_recording = done_recording_q;
    assign recording      = recording_q;
    assign full           = full_q;

endmodule

// File: doc/record_controller.md
RECORD_CONTROLLER -- requirements
Module: record_controller

Interface
REQ-001 SHALL have port: clk  input  1  system clock; all state on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: beat  input  1  one-cycle tempo pulse.
REQ-004 SHALL have port: master_state  input  2  mode (JAM_SESH=00, COMPOSER=01, SONG_PLAYER=10).
REQ-005 SHALL have port: record_button  input  1  one-cycle start/stop pulse.
REQ-006 SHALL have port: note_valid  input  1  one-cycle pulse; note_in is a new key event.
REQ-007 SHALL have port: note_in  input  6  note index; 0 means rest (keys released).
REQ-008 SHALL have port: write_enable  output  1  song-RAM write strobe, one cycle per entry.
REQ-009 SHALL have port: write_address  output  7  song-RAM entry index.
REQ-010 SHALL have port: write_payload  output  16  {rest[15], note[14:9], duration[8:3], meta[2:0]=000}.
REQ-011 SHALL have port: done_recording  output  1  one-cycle pulse; write_address holds last valid index.
REQ-012 SHALL have port: recording  output  1  high in REC and FLUSH.
REQ-013 SHALL have port: full  output  1  high from write to index 127 until next recording starts.

Function
REQ-014 SHALL implement FSM states IDLE, REC, FLUSH, DONE; all outputs registered.
REQ-015 IDLE: record_button while master_state==COMPOSER SHALL enter REC with addr=0, cur_note=0 (rest), dur=0, full=0; record_button in other modes ignored.
REQ-016 REC: each beat SHALL increment dur (6-bit).
REQ-017 REC: note_valid with note_in!=cur_note and dur>0 SHALL write entry {cur_note==0, cur_note, dur, 000} at addr next cycle, then addr+1, cur_note=note_in, dur=0.
REQ-018 REC: note_valid with dur==0 SHALL replace cur_note without writing (no zero-duration entries); note_in==cur_note SHALL be ignored.
REQ-019 REC: beat taking dur to 63 SHALL write that entry with duration 63, then restart dur=0 with same cur_note (long-note split).
REQ-020 beat and note_valid in the same cycle: beat SHALL be credited to old cur_note before the entry is formed.
REQ-021 Stop condition (record_button, or master_state!=COMPOSER) SHALL move REC to FLUSH; stop wins over a same-cycle note_valid (note discarded) but beat is still credited.
REQ-022 FLUSH: if dur>0 SHALL write the final entry, then go to DONE; if dur==0 SHALL go to DONE directly.
REQ-023 DONE: if at least one entry was written SHALL pulse done_recording one cycle with write_address=last written index; otherwise no pulse; then IDLE.
REQ-024 A write to index 127 SHALL set full and go to DONE without FLUSH; pending dur is discarded.
REQ-025 write_enable SHALL never exceed one write per cycle; write_address/payload SHALL be stable while write_enable is high.
REQ-026 rest bit SHALL equal (note field==0); meta field SHALL be 000.

Reset
REQ-027 reset low SHALL asynchronously force IDLE, addr=0, dur=0, cur_note=0, and write_enable, write_address, write_payload, done_recording, recording, full all to 0.
REQ-028 Reset mid-REC SHALL abandon the recording with no done_recording pulse.

Structure
REQ-029 master_state encodings, payload field positions, MAX_DUR=63 and RAM_DEPTH=128 SHALL live in the shared song package used by song_player.
REQ-030 Single module; no sub-module.

Verification
REQ-031 COMPOSER, record_button, note 23 for 5 beats, note 24 for 5 beats, record_button -> writes addr0={0,23,5,0}, addr1={0,24,5,0}; done_recording with write_address=1.
REQ-032 note 22 held 70 beats then stop -> addr0={0,22,63,0}, addr1={0,22,7,0}; done at write_address=1.
REQ-033 note 10 for 3 beats, release (note 0) 4 beats, note 11 for 2 beats, stop -> {0,10,3}, {1,0,4}, {0,11,2}; rest bit set on middle entry.
REQ-034 beat and note_valid(note 5) same cycle after 2 beats of note 9 -> entry {0,9,3}; master_state to JAM_SESH mid-note -> final entry flushed, done pulses.
REQ-035 128 alternating 1-beat notes -> write to 127, full=1, done with write_address=127, no 129th write.
REQ-036 record_button in SONG_PLAYER -> stays IDLE; reset low mid-REC -> all outputs 0, no done_recording.
